// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - two-value decimal converter with 8-digit multiplexed seven-segment scan
//
// Converts `bigger` and `smaller` (each saturated to SAT_MAX) to four BCD
// digits using a free-running 16-cycle double-dabble sequence
// (IDLE 1, CONV 14, COMMIT 1). Both digit banks update on the same edge, so a
// bank never shows a mix of old and new digits. The eight digits are scanned
// one at a time. The scan moves to the next digit every REFRESH_DIV clocks.
//
// Optional feature: define SEG_LEADING_ZERO_BLANK_EN to blank leading zeros
// within each 4-digit group. The units digit of a group is never blanked.
//
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset; blanks the display while high
//   bigger[31:0]    unsigned value shown on d7..d4
//   smaller[31:0]   unsigned value shown on d3..d0
//   sa..sg          segment drives, active-low
//   d0..d7          digit anodes, active-low, d0 rightmost

module seg_scan_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int SAT_MAX     = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bigger,
  input  logic [31:0] smaller,
  output logic        sa,
  output logic        sb,
  output logic        sc,
  output logic        sd,
  output logic        se,
  output logic        sf,
  output logic        sg,
  output logic        d0,
  output logic        d1,
  output logic        d2,
  output logic        d3,
  output logic        d4,
  output logic        d5,
  output logic        d6,
  output logic        d7
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  state_t        state;
  logic [3:0]    bit_cnt;
  // Each shift register holds {bcd[15:0], bin[13:0]}.
  logic [29:0]   big_sr;
  logic [29:0]   small_sr;
  logic [15:0]   big_bank;
  logic [15:0]   small_bank;
  logic [CW-1:0] refresh_cnt;
  logic [2:0]    idx;
  logic [6:0]    seg_q;
  logic [7:0]    an_q;
  logic [31:0]   digits;
  logic [3:0]    cur_nib;
  logic          cur_blank;

  function automatic logic [13:0] sat14(input logic [31:0] v);
    if (v > 32'(SAT_MAX)) return 14'(SAT_MAX);
    else return v[13:0];
  endfunction

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [29:0] dd_step(input logic [29:0] r);
    logic [29:0] t;
    t = r;
    for (int n = 0; n < 4; n++) begin
      if (t[14 + 4*n +: 4] >= 4'd5) t[14 + 4*n +: 4] = t[14 + 4*n +: 4] + 4'd3;
    end
    return {t[28:0], 1'b0};
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [7:0] blank_q;

  // Per-group blank flags, bit 3 = thousands; the units digit is never blanked.
  function automatic logic [3:0] lz_flags(input logic [15:0] b);
    logic [3:0] f;
    f[3] = (b[15:12] == 4'd0);
    f[2] = f[3] && (b[11:8] == 4'd0);
    f[1] = f[2] && (b[7:4] == 4'd0);
    f[0] = 1'b0;
    return f;
  endfunction
`endif

  // Conversion FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      big_sr     <= 30'd0;
      small_sr   <= 30'd0;
      big_bank   <= 16'd0;
      small_bank <= 16'd0;
`ifdef SEG_LEADING_ZERO_BLANK_EN
      blank_q    <= 8'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          big_sr   <= {16'd0, sat14(bigger)};
          small_sr <= {16'd0, sat14(smaller)};
          bit_cnt  <= 4'd0;
          state    <= CONV;
        end
        CONV: begin
          big_sr   <= dd_step(big_sr);
          small_sr <= dd_step(small_sr);
          bit_cnt  <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd13) state <= COMMIT;
        end
        COMMIT: begin
          big_bank   <= big_sr[29:14];
          small_bank <= small_sr[29:14];
`ifdef SEG_LEADING_ZERO_BLANK_EN
          blank_q    <= {lz_flags(big_sr[29:14]), lz_flags(small_sr[29:14])};
`endif
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign digits  = {big_bank, small_bank};
  assign cur_nib = digits[{idx, 2'b00} +: 4];
`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign cur_blank = blank_q[idx];
`else
  assign cur_blank = 1'b0;
`endif

  // Refresh scan; segment and anode registers load on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      refresh_cnt <= '0;
      idx         <= 3'd0;
      seg_q       <= 7'h7F;
      an_q        <= 8'hFF;
    end else begin
      if (refresh_cnt == CW'(REFRESH_DIV - 1)) begin
        refresh_cnt <= '0;
        idx         <= idx + 3'd1;
      end else begin
        refresh_cnt <= refresh_cnt + 1'b1;
      end
      seg_q <= cur_blank ? 7'h7F : seg_decode(cur_nib);
      an_q  <= ~(8'b1 << idx);
    end
  end

  // The display is blanked as soon as rst is high, without waiting for an edge.
  assign {sa, sb, sc, sd, se, sf, sg} = seg_q | {7{rst}};
  assign {d7, d6, d5, d4, d3, d2, d1, d0} = an_q | {8{rst}};

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - directed self-checking bench for seg_scan_display

module tb_seg_scan_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] bigger = 32'd0;
  logic [31:0] smaller = 32'd0;
  logic        sa, sb, sc, sd, se, sf, sg;
  logic        d0, d1, d2, d3, d4, d5, d6, d7;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic [6:0]  got [8];
  int          checks = 0;
  int          errors = 0;
  int          idx;

  always #5 clk = ~clk;

  seg_scan_display #(.REFRESH_DIV(4), .SAT_MAX(9999)) dut (
    .clk(clk), .rst(rst), .bigger(bigger), .smaller(smaller),
    .sa(sa), .sb(sb), .sc(sc), .sd(sd), .se(se), .sf(sf), .sg(sg),
    .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7)
  );

  assign an  = {d7, d6, d5, d4, d3, d2, d1, d0};
  assign seg = {sa, sb, sc, sd, se, sf, sg};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-written segment table; nibble 4'hF stands for a blanked digit.
  function automatic logic [6:0] pat(input logic [3:0] v);
    case (v)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic observe(output int o_idx);
    int z;
    z = 0;
    o_idx = -1;
    for (int i = 0; i < 8; i++) begin
      if (an[i] == 1'b0) begin
        z++;
        o_idx = i;
      end
    end
    if (z != 1) o_idx = -1;
  endtask

  task automatic capture_frame(input string tag);
    int k_idx;
    for (int i = 0; i < 8; i++) got[i] = 'x;
    for (int k = 0; k < 32; k++) begin
      tick(1);
      observe(k_idx);
      chk({tag, "_one_anode"}, 32'(k_idx >= 0), 32'd1);
      if (k_idx >= 0) got[k_idx] = seg;
    end
  endtask

  // exp holds eight nibbles, nibble i = digit shown on d<i>.
  task automatic check_frame(input string tag, input logic [31:0] exp);
    logic [31:0] e;
    e = exp;
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_d%0d", tag, i), 32'(got[i]), 32'(pat(e[i*4 +: 4])));
  endtask

  initial begin
    logic [3:0] ed;

    // Reset display
    tick(3);
    chk("rst_anodes", 32'(an), 32'hFF);
    chk("rst_segs", 32'(seg), 32'h7F);
    rst = 1'b0;
    tick(1);
    chk("post_rst_anodes", 32'(an), 32'hFE);
    chk("post_rst_segs", 32'(seg), 32'(7'b0000001));
    tick(4);
    chk("scan_idx1", 32'(an), 32'hFD);
    tick(4);
    chk("scan_idx2", 32'(an), 32'hFB);

    // Decimal conversion
    bigger  = 32'd1234;
    smaller = 32'd56;
    tick(33);
    capture_frame("conv");
    check_frame("conv", 32'h12340056);

    // Saturation
    bigger  = 32'd12345;
    smaller = 32'hFFFF_FFFF;
    tick(33);
    capture_frame("sat");
    check_frame("sat", 32'h99999999);

    // Leading zeros
    bigger  = 32'd0;
    smaller = 32'd56;
    tick(33);
    capture_frame("lz");
`ifdef SEG_LEADING_ZERO_BLANK_EN
    check_frame("lz", 32'hFFF0FF56);
`else
    check_frame("lz", 32'h00000056);
`endif

    // Atomic update: edge 0 after release is IDLE; change lands in CONV cycle 5
    // of the second conversion, so 2222 commits at edge 47 and shows from 48.
    rst     = 1'b1;
    bigger  = 32'd1111;
    smaller = 32'd0;
    tick(2);
    rst = 1'b0;
    tick(21);
    bigger = 32'd2222;
    for (int e = 21; e < 64; e++) begin
      tick(1);
      observe(idx);
      chk($sformatf("atomic_idx_e%0d", e), 32'(idx), 32'((e / 4) % 8));
      if (idx >= 4)
        chk($sformatf("atomic_seg_e%0d", e), 32'(seg), 32'(e >= 48 ? pat(4'd2) : pat(4'd1)));
    end

    // Mid-conversion reset
    tick(3);
    rst = 1'b1;
    tick(2);
    chk("midrst_anodes", 32'(an), 32'hFF);
    chk("midrst_segs", 32'(seg), 32'h7F);
    smaller = 32'd7;
    rst = 1'b0;
    for (int e = 0; e < 48; e++) begin
      tick(1);
      observe(idx);
      chk($sformatf("midrst_idx_e%0d", e), 32'(idx), 32'((e / 4) % 8));
      if (e < 16)      ed = 4'd0;
      else if (idx >= 4) ed = 4'd2;
      else if (idx == 0) ed = 4'd7;
      else             ed = 4'd0;
      chk($sformatf("midrst_seg_e%0d", e), 32'(seg), 32'(pat(ed)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_display.md
Name: seg_scan_display

Overview:
- Downstream consumer of the pipelined CPU's result words, for example the two data-memory result locations.
- Converts two unsigned 32-bit values to 4-digit decimal each using sequential double-dabble.
- Time-multiplexes the result onto the 8-digit common-anode seven-segment display.
- Left group (d7..d4) shows `bigger`; right group (d3..d0) shows `smaller`.

Parameters:
- REFRESH_DIV, 100000: clocks per digit slot (1 kHz digit rate at 100 MHz); legal range ≥2.
- SAT_MAX, 9999: saturation ceiling applied before conversion; must fit in 14 bits.

Ports:
- clk  input  1  system clock; single clock domain.
- rst  input  1  synchronous, active-high reset.
- bigger  input  32  unsigned value shown on d7..d4.
- smaller  input  32  unsigned value shown on d3..d0.
- sa, sb, sc, sd, se, sf, sg  output  1 each  segment drives, active-low.
- d0, d1, d2, d3, d4, d5, d6, d7  output  1 each  digit anodes, active-low; d0 is the rightmost digit.

Behaviour:
- Reset (rst high at a clk edge):
  - FSM goes to IDLE; both BCD digit banks are cleared to 0.
  - Scan index = 0; refresh counter = 0.
  - While rst is high, all anodes and all segments are forced to 1 (display blank).
  - Reset mid-conversion aborts the conversion; no partial commit.
- Conversion FSM (states IDLE, CONV, COMMIT):
  - Free-running, with a 16-cycle period.
  - IDLE, 1 cycle:
    - Samples `bigger` and `smaller`.
    - Each value is saturated: if value > SAT_MAX, SAT_MAX is used; otherwise the low 14 bits are used.
    - Loads two shift registers (14-bit binary + 16-bit BCD each).
    - Clears the bit counter; goes to CONV.
  - CONV, exactly 14 cycles. Each cycle, for both converters in parallel:
    - Every BCD nibble ≥5 gets +3 first.
    - Then the whole register shifts left by 1.
    - After the 14th shift, go to COMMIT.
  - COMMIT, 1 cycle:
    - Both 4-nibble results are copied atomically into the display digit banks.
    - Goes to IDLE.
- Timing and input handling:
  - Sample-to-display latency is 15 clocks.
  - Worst-case input-change-to-display latency is 31 clocks.
  - Input changes during CONV/COMMIT are ignored until the next IDLE.
  - The display never shows a mix of old and new digits within one bank.
- Refresh:
  - The counter counts 0..REFRESH_DIV-1 and wraps.
  - On wrap, the scan index advances 0→1→…→7→0.
- Outputs:
  - Exactly one anode is low after reset: d[index]; all others are high.
  - Digit mapping: index 7..4 = bigger thousands/hundreds/tens/units; index 3..0 = smaller thousands/hundreds/tens/units.
- Segments:
  - Registered decode of the selected nibble, so segments and anode change on the same edge.
  - Patterns as {sa..sg}: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100.
  - Any other nibble value gives all 1s (unreachable by construction).

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN
- Defined:
  - Within each 4-digit group, zeros to the left of the most significant nonzero digit are blanked: all segments 1, anode still low.
  - The units digit of a group is never blanked, so a value of 0 shows a single "0".
  - The blank decision is made at COMMIT and stored per digit.
- Undefined:
  - All 8 digits always display, including leading zeros.
  - No blank-flag storage is synthesized.

Test Plan (REFRESH_DIV=4 throughout):
- Reset display: rst=1 for 3 clocks → all d*=1 and all s*=1. After release → d0=0, {sa..sg}=0000001; index advances every 4 clocks.
- Decimal conversion: bigger=1234, smaller=56, wait 32 clocks, then scan one full frame. Required per-digit patterns:
  - d7=1001111, d6=0010010, d5=0000110, d4=1001100
  - d3=0000001, d2=0000001, d1=0100100, d0=0100000
- Saturation: bigger=12345, smaller=32'hFFFFFFFF → all 8 digits show 9 (0000100).
- Atomic update: bigger changes 1111→2222 on the 5th CONV cycle. Required:
  - The display shows 1111 until the first COMMIT, and never a mix such as 1122.
  - 2222 appears at the next COMMIT, within 31 clocks of the change.
- Mid-conversion reset: assert rst during CONV → digits return to 0. The next conversion after release completes normally with 16-cycle period alignment restarted from IDLE.
- SEG_LEADING_ZERO_BLANK_EN defined, smaller=56 and bigger=0:
  - d3, d2 = 1111111 with anode low; d1=0100100, d0=0100000.
  - d7..d5 blank; d4=0000001.
